// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding,
// default operand width and the iteration counter width.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int MULT_WIDTH = 64;

   // One extra bit so the counter can reach WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/multiplier_if.sv
// Request/result bundle for the multiplier: start/operands in, HI/LO and
// busy/ready status out.
interface multiplier_if #(parameter int WIDTH = 64);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             ready;

   modport master (output start, is_signed, a, b, input hi, lo, busy, ready);
   modport slave  (input start, is_signed, a, b, output hi, lo, busy, ready);
endinterface

// File: rtl/mult_abs.sv
// Combinational conditional two's-complement negate; used both for operand
// magnitudes and for the final product sign fix.
module mult_abs #(
   parameter int W = 64
) (
   input  logic         neg,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);
   assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
endmodule

// File: rtl/multiplier.sv
// Sequential 64-bit DMULT/DMULTU multiplier: one multiplier bit per cycle,
// magnitude shift-add then sign fix. Option: MULT_EARLY_TERM_EN stops RUN once
// the remaining multiplier bits are all zero.
module multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   multiplier_if.slave   bus
);
   localparam int CNT_W = cnt_width(WIDTH);

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic                 ready_q, ready_d;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   prod;
   logic                 last_iter;

   mult_abs #(.W(WIDTH)) u_abs_a (
      .neg (bus.is_signed & bus.a[WIDTH-1]),
      .x   (bus.a),
      .y   (a_mag)
   );

   mult_abs #(.W(WIDTH)) u_abs_b (
      .neg (bus.is_signed & bus.b[WIDTH-1]),
      .x   (bus.b),
      .y   (b_mag)
   );

   mult_abs #(.W(2*WIDTH)) u_abs_p (
      .neg (neg_q),
      .x   (acc_q),
      .y   (prod)
   );

`ifdef MULT_EARLY_TERM_EN
   // Leave after the iteration that shifts out the last set multiplier bit.
   assign last_iter = (cnt_q == CNT_W'(WIDTH-1)) || (mplier_q[WIDTH-1:1] == '0);
`else
   assign last_iter = (cnt_q == CNT_W'(WIDTH-1));
`endif

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      ready_d  = ready_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               acc_d    = '0;
               cnt_d    = '0;
               neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               ready_d  = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_iter) state_d = FIX;
         end
         FIX: begin
            {hi_d, lo_d} = prod;
            ready_d      = 1'b1;
            state_d      = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.ready = ready_q;
   assign bus.busy  = (state_q == RUN) || (state_q == FIX);

endmodule
